collision_probe: RTL and testbench

Movement arbiter between the player-input logic and the collision RAM. On each move request it computes the candidate sprite position, rejects it if it leaves the map, and reads the collision RAM at three points on the sprite's leading edge. It grants the move only if no probe is blocked. It owns the collision RAM read port (1-cycle registered read) and returns the committed position to the sprite/scroll logic.

---
 rtl/collision_probe.sv | 209 ++++++++++++++++++++
 tb/tb_collision_probe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/collision_probe.sv
// collision_probe: arbitrates a single sprite move against the collision RAM.
// A request latches the inputs, computes the candidate position, rejects it if
// it leaves the map, otherwise reads three points on the leading edge and
// grants the move only if none of them is blocked.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for req; outputs of the last result held
// CALC      | candidate + bounds check; issue probe 0 or reject
// PROBE     | issue probes 1 and 2; sample probe 0 data
// DONE_WAIT | sample probe 1 and 2 data; raise done with the verdict
module collision_probe #(
   parameter int MAP_W = 320,
   parameter int MAP_H = 240,
   parameter int SPR_W = 16,
   parameter int SPR_H = 24
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        req,
   input  logic [1:0]  dir,
   input  logic [3:0]  step,
   input  logic [8:0]  cur_x,
   input  logic [7:0]  cur_y,
   output logic [18:0] rd_addr,
   input  logic [3:0]  rd_data,
   output logic        busy,
   output logic        done,
   output logic        allow,
   output logic [8:0]  new_x,
   output logic [7:0]  new_y
);

   typedef enum logic [1:0] {IDLE, CALC, PROBE, DONE_WAIT} state_t;

   localparam logic [1:0]  DIR_UP    = 2'd0;
   localparam logic [1:0]  DIR_DOWN  = 2'd1;
   localparam logic [1:0]  DIR_LEFT  = 2'd2;
   localparam logic [9:0]  X_MAX     = 10'(MAP_W - SPR_W);
   localparam logic [8:0]  Y_MAX     = 9'(MAP_H - SPR_H);
   localparam logic [18:0] PITCH     = 19'(MAP_W);
   localparam logic [8:0]  X_HALF    = 9'(SPR_W / 2);
   localparam logic [8:0]  X_LAST    = 9'(SPR_W - 1);
   localparam logic [7:0]  Y_HALF    = 8'(SPR_H / 2);
   localparam logic [7:0]  Y_LAST    = 8'(SPR_H - 1);

   state_t      state_q, state_d;
   logic        ph_q, ph_d;
   logic [1:0]  dir_q, dir_d;
   logic [3:0]  step_q, step_d;
   logic [8:0]  x_q, x_d;
   logic [7:0]  y_q, y_d;
   logic        blocked_q, blocked_d;
   logic [18:0] rd_addr_q, rd_addr_d;
   logic        done_q, done_d;
   logic        allow_q, allow_d;
   logic [8:0]  new_x_q, new_x_d;
   logic [7:0]  new_y_q, new_y_d;

   // Extra MSB on each axis turns an underflow into a huge value the bounds
   // compare rejects.
   logic [9:0]  cand_x;
   logic [8:0]  cand_y;
   logic        in_bounds;
   logic [1:0]  probe_k;
   logic [8:0]  off_x, px;
   logic [7:0]  off_y, py;
   logic [18:0] probe_addr;
   logic        final_blk;
   logic        unused_rd;

   assign unused_rd = ^rd_data[3:1];

   // Candidate position from the latched request, plus bounds check.
   always_comb begin
      cand_x = {1'b0, x_q};
      cand_y = {1'b0, y_q};
      case (dir_q)
         DIR_UP:   cand_y = {1'b0, y_q} - {5'd0, step_q};
         DIR_DOWN: cand_y = {1'b0, y_q} + {5'd0, step_q};
         DIR_LEFT: cand_x = {1'b0, x_q} - {6'd0, step_q};
         default:  cand_x = {1'b0, x_q} + {6'd0, step_q};
      endcase
      in_bounds = (cand_x <= X_MAX) && (cand_y <= Y_MAX);
   end

   // Leading-edge probe point k and its linear RAM address.
   always_comb begin
      case (probe_k)
         2'd0:    begin off_x = 9'd0;   off_y = 8'd0;   end
         2'd1:    begin off_x = X_HALF; off_y = Y_HALF; end
         default: begin off_x = X_LAST; off_y = Y_LAST; end
      endcase
      case (dir_q)
         DIR_UP:   begin px = cand_x[8:0] + off_x;  py = cand_y[7:0];          end
         DIR_DOWN: begin px = cand_x[8:0] + off_x;  py = cand_y[7:0] + Y_LAST; end
         DIR_LEFT: begin px = cand_x[8:0];          py = cand_y[7:0] + off_y;  end
         default:  begin px = cand_x[8:0] + X_LAST; py = cand_y[7:0] + off_y;  end
      endcase
      probe_addr = ({11'd0, py} * PITCH) + {10'd0, px};
   end

   // Next-state and output logic.
   always_comb begin
      state_d   = state_q;
      ph_d      = ph_q;
      dir_d     = dir_q;
      step_d    = step_q;
      x_d       = x_q;
      y_d       = y_q;
      blocked_d = blocked_q;
      rd_addr_d = rd_addr_q;
      done_d    = 1'b0;
      allow_d   = allow_q;
      new_x_d   = new_x_q;
      new_y_d   = new_y_q;
      probe_k   = 2'd0;
      final_blk = blocked_q | rd_data[0];
      case (state_q)
         IDLE: begin
            if (req) begin
               dir_d     = dir;
               step_d    = step;
               x_d       = cur_x;
               y_d       = cur_y;
               blocked_d = 1'b0;
               ph_d      = 1'b0;
               state_d   = CALC;
            end
         end
         CALC: begin
            if (in_bounds) begin
               rd_addr_d = probe_addr;
               ph_d      = 1'b0;
               state_d   = PROBE;
            end else begin
               done_d  = 1'b1;
               allow_d = 1'b0;
               new_x_d = x_q;
               new_y_d = y_q;
               state_d = IDLE;
            end
         end
         PROBE: begin
            probe_k   = ph_q ? 2'd2 : 2'd1;
            rd_addr_d = probe_addr;
            if (!ph_q) begin
               ph_d = 1'b1;
            end else begin
               blocked_d = final_blk;
               ph_d      = 1'b0;
               state_d   = DONE_WAIT;
            end
         end
         DONE_WAIT: begin
            if (!ph_q) begin
               blocked_d = final_blk;
               ph_d      = 1'b1;
            end else begin
               done_d  = 1'b1;
               allow_d = ~final_blk;
               new_x_d = final_blk ? x_q : cand_x[8:0];
               new_y_d = final_blk ? y_q : cand_y[7:0];
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         ph_q      <= 1'b0;
         dir_q     <= 2'd0;
         step_q    <= 4'd0;
         x_q       <= 9'd0;
         y_q       <= 8'd0;
         blocked_q <= 1'b0;
         rd_addr_q <= 19'd0;
         done_q    <= 1'b0;
         allow_q   <= 1'b0;
         new_x_q   <= 9'd0;
         new_y_q   <= 8'd0;
      end else begin
         state_q   <= state_d;
         ph_q      <= ph_d;
         dir_q     <= dir_d;
         step_q    <= step_d;
         x_q       <= x_d;
         y_q       <= y_d;
         blocked_q <= blocked_d;
         rd_addr_q <= rd_addr_d;
         done_q    <= done_d;
         allow_q   <= allow_d;
         new_x_q   <= new_x_d;
         new_y_q   <= new_y_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign allow   = allow_q;
   assign rd_addr = rd_addr_q;
   assign new_x   = new_x_q;
   assign new_y   = new_y_q;

endmodule

// File: tb/tb_collision_probe.sv
// Directed bench for collision_probe with a small registered-read RAM model.
module tb_collision_probe;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        req = 1'b0;
   logic [1:0]  dir = 2'd0;
   logic [3:0]  step = 4'd0;
   logic [8:0]  cur_x = 9'd0;
   logic [7:0]  cur_y = 8'd0;
   logic [18:0] rd_addr;
   logic [3:0]  rd_data;
   logic        busy, done, allow;
   logic [8:0]  new_x;
   logic [7:0]  new_y;

   int n_cmp = 0;
   int n_bad = 0;

   logic [18:0] blk_addr = '1;
   logic [3:0]  blk_val  = 4'h0;
   logic [18:0] pa [3];
   logic        busy0;

   collision_probe dut (
      .Clk(Clk), .Reset_n(Reset_n), .req(req), .dir(dir), .step(step),
      .cur_x(cur_x), .cur_y(cur_y), .rd_addr(rd_addr), .rd_data(rd_data),
      .busy(busy), .done(done), .allow(allow), .new_x(new_x), .new_y(new_y)
   );

   always #5 Clk = ~Clk;

   // Collision RAM: one-cycle registered read, all zero except one word.
   always @(posedge Clk) rd_data <= (rd_addr == blk_addr) ? blk_val : 4'h0;

   task automatic run_req(input logic [1:0] d, input logic [3:0] s,
                          input logic [8:0] x, input logic [7:0] y, output int lat);
      @(negedge Clk);
      dir = d; step = s; cur_x = x; cur_y = y; req = 1'b1;
      @(posedge Clk); #1;
      req = 1'b0;
      busy0 = busy;
      dir = ~d; step = 4'hF; cur_x = 9'd7; cur_y = 8'd250;
      lat = -1;
      pa[0] = 'x; pa[1] = 'x; pa[2] = 'x;
      for (int i = 1; i <= 20; i++) begin
         @(posedge Clk); #1;
         if (i <= 3) pa[i-1] = rd_addr;
         if (done) begin lat = i; break; end
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; req = 1'b1; dir = 2'd3; step = 4'd2; cur_x = 9'd100; cur_y = 8'd100;
      repeat (3) @(posedge Clk);
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if ({done, allow} !== 2'b00) begin n_bad++; $display("FAIL reset_done_allow: got %b want 00", {done, allow}); end
      n_cmp++; if (rd_addr !== 19'd0) begin n_bad++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
      n_cmp++; if ({new_x, new_y} !== 17'd0) begin n_bad++; $display("FAIL reset_new: got %0d,%0d want 0,0", new_x, new_y); end
      @(negedge Clk);
      req = 1'b0; Reset_n = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      n_cmp++; if ({busy, done, allow, rd_addr, new_x, new_y} !== 39'd0) begin n_bad++;
         $display("FAIL post_reset_idle: got busy=%b done=%b allow=%b addr=%0d new=%0d,%0d want all 0", busy, done, allow, rd_addr, new_x, new_y); end
   endtask

   task automatic test_free_move();
      int lat;
      logic [18:0] exp_a [3];
      exp_a[0] = 19'd32117; exp_a[1] = 19'd35957; exp_a[2] = 19'd39477;
      blk_addr = '1; blk_val = 4'h0;
      run_req(2'd3, 4'd2, 9'd100, 8'd100, lat);
      n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL free_busy: got %b want 1", busy0); end
      n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL free_latency: got %0d want 5", lat); end
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if (pa[k] !== exp_a[k]) begin n_bad++; $display("FAIL free_probe%0d: got %0d want %0d", k, pa[k], exp_a[k]); end
      end
      n_cmp++; if (allow !== 1'b1) begin n_bad++; $display("FAIL free_allow: got %b want 1", allow); end
      n_cmp++; if (new_x !== 9'd102 || new_y !== 8'd100) begin n_bad++; $display("FAIL free_new: got %0d,%0d want 102,100", new_x, new_y); end
      @(posedge Clk); #1;
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL free_done_once: got done=%b busy=%b want 0 0", done, busy); end
   endtask

   task automatic test_blocked();
      int lat;
      blk_addr = 19'd35957; blk_val = 4'b0001;
      run_req(2'd3, 4'd2, 9'd100, 8'd100, lat);
      n_cmp++; if (lat !== 5 || allow !== 1'b0) begin n_bad++; $display("FAIL blk_mid: got lat=%0d allow=%b want 5 0", lat, allow); end
      n_cmp++; if (new_x !== 9'd100 || new_y !== 8'd100) begin n_bad++; $display("FAIL blk_mid_new: got %0d,%0d want 100,100", new_x, new_y); end
      blk_val = 4'b1110;
      run_req(2'd3, 4'd2, 9'd100, 8'd100, lat);
      n_cmp++; if (allow !== 1'b1 || new_x !== 9'd102) begin n_bad++; $display("FAIL blk_upper_bits: got allow=%b x=%0d want 1 102", allow, new_x); end
      blk_addr = 19'd32117; blk_val = 4'b0001;
      run_req(2'd3, 4'd2, 9'd100, 8'd100, lat);
      n_cmp++; if (allow !== 1'b0) begin n_bad++; $display("FAIL blk_first: got allow=%b want 0", allow); end
      blk_addr = 19'd39477;
      run_req(2'd3, 4'd2, 9'd100, 8'd100, lat);
      n_cmp++; if (allow !== 1'b0) begin n_bad++; $display("FAIL blk_last: got allow=%b want 0", allow); end
      blk_addr = '1; blk_val = 4'h0;
   endtask

   task automatic test_bounds();
      int lat;
      run_req(2'd2, 4'd1, 9'd0, 8'd50, lat);
      n_cmp++; if (lat !== 1 || allow !== 1'b0) begin n_bad++; $display("FAIL oob_left: got lat=%0d allow=%b want 1 0", lat, allow); end
      n_cmp++; if (new_x !== 9'd0 || new_y !== 8'd50) begin n_bad++; $display("FAIL oob_left_new: got %0d,%0d want 0,50", new_x, new_y); end
      n_cmp++; if (rd_addr !== 19'd39477) begin n_bad++; $display("FAIL oob_left_addr: got %0d want 39477", rd_addr); end
      run_req(2'd3, 4'd1, 9'd303, 8'd0, lat);
      n_cmp++; if (lat !== 5 || allow !== 1'b1) begin n_bad++; $display("FAIL edge_right: got lat=%0d allow=%b want 5 1", lat, allow); end
      n_cmp++; if (pa[0] !== 19'd319 || pa[1] !== 19'd4159 || pa[2] !== 19'd7679) begin n_bad++;
         $display("FAIL edge_right_probes: got %0d %0d %0d want 319 4159 7679", pa[0], pa[1], pa[2]); end
      n_cmp++; if (new_x !== 9'd304 || new_y !== 8'd0) begin n_bad++; $display("FAIL edge_right_new: got %0d,%0d want 304,0", new_x, new_y); end
      run_req(2'd3, 4'd2, 9'd303, 8'd0, lat);
      n_cmp++; if (lat !== 1 || allow !== 1'b0 || new_x !== 9'd303) begin n_bad++; $display("FAIL oob_right: got lat=%0d allow=%b x=%0d want 1 0 303", lat, allow, new_x); end
      n_cmp++; if (rd_addr !== 19'd7679) begin n_bad++; $display("FAIL oob_right_addr: got %0d want 7679", rd_addr); end
      run_req(2'd0, 4'd4, 9'd10, 8'd3, lat);
      n_cmp++; if (lat !== 1 || allow !== 1'b0 || new_y !== 8'd3) begin n_bad++; $display("FAIL oob_up: got lat=%0d allow=%b y=%0d want 1 0 3", lat, allow, new_y); end
      run_req(2'd0, 4'd0, 9'd100, 8'd100, lat);
      n_cmp++; if (lat !== 5 || allow !== 1'b1 || new_x !== 9'd100 || new_y !== 8'd100) begin n_bad++;
         $display("FAIL step0: got lat=%0d allow=%b new=%0d,%0d want 5 1 100,100", lat, allow, new_x, new_y); end
      n_cmp++; if (pa[0] !== 19'd32100 || pa[1] !== 19'd32108 || pa[2] !== 19'd32115) begin n_bad++;
         $display("FAIL step0_probes: got %0d %0d %0d want 32100 32108 32115", pa[0], pa[1], pa[2]); end
   endtask

   task automatic test_reset_mid();
      int lat;
      int n_done;
      @(negedge Clk);
      dir = 2'd3; step = 4'd2; cur_x = 9'd100; cur_y = 8'd100; req = 1'b1;
      @(posedge Clk); #1;
      req = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Reset_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || rd_addr !== 19'd0 || allow !== 1'b0) begin n_bad++;
         $display("FAIL mid_reset: got busy=%b done=%b addr=%0d allow=%b want 0 0 0 0", busy, done, rd_addr, allow); end
      n_done = 0;
      req = 1'b1;
      repeat (4) begin @(posedge Clk); #1; if (done) n_done++; end
      @(negedge Clk);
      req = 1'b0; Reset_n = 1'b1;
      repeat (3) begin @(posedge Clk); #1; if (done) n_done++; end
      n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL mid_reset_no_done: got %0d pulses want 0", n_done); end
      run_req(2'd1, 4'd1, 9'd50, 8'd50, lat);
      n_cmp++; if (pa[0] !== 19'd23730 || pa[1] !== 19'd23738 || pa[2] !== 19'd23745) begin n_bad++;
         $display("FAIL after_reset_probes: got %0d %0d %0d want 23730 23738 23745", pa[0], pa[1], pa[2]); end
      n_cmp++; if (lat !== 5 || allow !== 1'b1 || new_x !== 9'd50 || new_y !== 8'd51) begin n_bad++;
         $display("FAIL after_reset_result: got lat=%0d allow=%b new=%0d,%0d want 5 1 50,51", lat, allow, new_x, new_y); end
   endtask

   task automatic test_back_to_back();
      int t1, t2;
      logic held_ok;
      t1 = -1; t2 = -1; held_ok = 1'b1;
      @(negedge Clk);
      dir = 2'd3; step = 4'd2; cur_x = 9'd100; cur_y = 8'd100; req = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge Clk); #1;
         if (i == 2) begin dir = 2'd0; step = 4'd9; cur_x = 9'd7; cur_y = 8'd7; end
         if (t1 >= 0 && i > t1 && !done && (allow !== 1'b1 || new_x !== 9'd102 || new_y !== 8'd100)) held_ok = 1'b0;
         if (done) begin
            if (t1 < 0) begin
               t1 = i;
               dir = 2'd1; step = 4'd1; cur_x = 9'd50; cur_y = 8'd50;
            end else begin
               t2 = i; req = 1'b0; break;
            end
         end
      end
      req = 1'b0;
      n_cmp++; if (t1 !== 5 || t2 - t1 !== 6) begin n_bad++; $display("FAIL b2b_spacing: got t1=%0d t2=%0d want 5 11", t1, t2); end
      n_cmp++; if (held_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_held: got %b want 1", held_ok); end
      n_cmp++; if (allow !== 1'b1 || new_x !== 9'd50 || new_y !== 8'd51) begin n_bad++;
         $display("FAIL b2b_second: got allow=%b new=%0d,%0d want 1 50,51", allow, new_x, new_y); end
      repeat (8) @(posedge Clk);
      t1 = -1; t2 = -1;
      @(negedge Clk);
      dir = 2'd2; step = 4'd1; cur_x = 9'd0; cur_y = 8'd50; req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge Clk); #1;
         if (done) begin
            if (t1 < 0) t1 = i;
            else begin t2 = i; req = 1'b0; break; end
         end
      end
      req = 1'b0;
      n_cmp++; if (t1 !== 1 || t2 - t1 !== 2) begin n_bad++; $display("FAIL b2b_reject_spacing: got t1=%0d t2=%0d want 1 3", t1, t2); end
      repeat (4) @(posedge Clk);
   endtask

   initial begin
      test_reset();
      test_free_move();
      test_blocked();
      test_bounds();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
